// File: rtl/icpu_pkg.sv
// Shared definitions for the ICPU decode stage: opcode map, kind bit
// positions, skid-buffer state encoding and the instruction width helper.
// Imported by every file in the decode slice.
package icpu_pkg;

  // Defined opcodes; wider opcode fields compare against zero-extended values
  localparam int OP_NOP  = 0;
  localparam int OP_NEW  = 1;
  localparam int OP_LINK = 2;
  localparam int OP_EVAL = 5;

  // Bit positions inside the one-hot command kind {EVAL, LINK, NEW, NOP}
  localparam int KIND_NOP  = 0;
  localparam int KIND_NEW  = 1;
  localparam int KIND_LINK = 2;
  localparam int KIND_EVAL = 3;
  localparam int KIND_W    = 4;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Packed instruction width: opcode, destination, then NSRC source fields
  function automatic int icpu_instr_w(input int opc_w, input int reg_w, input int nsrc);
    return opc_w + reg_w * (1 + nsrc);
  endfunction

endpackage

// File: rtl/icpu_skid_buf.sv
// Two-entry valid/ready buffer (main register plus skid register).
// Latency: a word accepted at edge t is presented on out_valid in cycle t+1.
// Backpressure: in_ready comes from registered occupancy only; drops when both entries hold data.
module icpu_skid_buf
  import icpu_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q;
  skid_state_e  state_d;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         deliver;
  logic         load_main_in;
  logic         load_main_skid;
  logic         load_skid;

  // in_ready never looks at out_ready, so no combinational path crosses the stage
  assign in_ready  = !rst && (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Next occupancy and register load selects; flush discards both entries
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d      = SKID_ONE;
          load_main_in = 1'b1;
        end
      end
      SKID_ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = SKID_FULL;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (deliver) begin
          state_d        = SKID_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = SKID_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers; the skid entry always drains into main, keeping order
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/icpu_decode_stage.sv
// Instruction decode: splits opcode/dest/sources, classifies the opcode, counts illegal words.
// Latency: one cycle from accept to out_valid; one word per cycle while out_ready is high.
// Backpressure: two-entry skid buffer; in_ready falls only when both entries are occupied.
module icpu_decode_stage
  import icpu_pkg::*;
#(
  parameter  int OPC_W   = 4,
  parameter  int REG_W   = 4,
  parameter  int NSRC    = 2,
  parameter  int CNT_W   = 16,
  localparam int INSTR_W = icpu_instr_w(OPC_W, REG_W, NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPC_W-1:0]      out_opcode,
  output logic [REG_W-1:0]      out_dest,
  output logic [NSRC*REG_W-1:0] out_src,
  output logic [3:0]            out_kind,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      illegal_cnt
);

  localparam int SRC_W = NSRC * REG_W;
  localparam int PAY_W = OPC_W + REG_W + SRC_W + KIND_W + 1;

  // Idle payload: all fields zero, kind = NOP, not illegal
  localparam logic [PAY_W-1:0] PAY_RST = {{(PAY_W - KIND_W - 1){1'b0}}, 4'b0001, 1'b0};

  logic [OPC_W-1:0]  dec_opcode;
  logic [REG_W-1:0]  dec_dest;
  logic [SRC_W-1:0]  dec_src;
  logic [KIND_W-1:0] dec_kind;
  logic              dec_illegal;
  logic [PAY_W-1:0]  in_pay;
  logic [PAY_W-1:0]  out_pay;
  logic [CNT_W-1:0]  cnt_q;

  // Field extraction and opcode classification on the incoming word.
  // src[0] sits next to dest in the packed word but lands at the LSBs of out_src.
  always_comb begin
    dec_opcode  = in_instr[INSTR_W-1 -: OPC_W];
    dec_dest    = in_instr[SRC_W +: REG_W];
    dec_src     = '0;
    for (int i = 0; i < NSRC; i++) begin
      dec_src[i*REG_W +: REG_W] = in_instr[(NSRC-1-i)*REG_W +: REG_W];
    end
    dec_kind    = '0;
    dec_illegal = 1'b0;
    case (32'(dec_opcode))
      OP_NOP:  dec_kind[KIND_NOP]  = 1'b1;
      OP_NEW:  dec_kind[KIND_NEW]  = 1'b1;
      OP_LINK: dec_kind[KIND_LINK] = 1'b1;
      OP_EVAL: dec_kind[KIND_EVAL] = 1'b1;
      default: begin
        dec_kind[KIND_NOP] = 1'b1;
        dec_illegal        = 1'b1;
      end
    endcase
  end

  assign in_pay = {dec_opcode, dec_dest, dec_src, dec_kind, dec_illegal};

  icpu_skid_buf #(
    .W       (PAY_W),
    .RST_VAL (PAY_RST)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay)
  );

  assign {out_opcode, out_dest, out_src, out_kind, out_illegal} = out_pay;

  // Count illegal words as they leave the stage; saturate instead of wrapping, survive flush
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && out_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_icpu_decode_stage.sv
// Scoreboard bench for icpu_decode_stage: default build (A) and a wide build
// with a 4-bit counter (B). Drivers push expected decodes when a word is
// accepted; monitors compare whenever the DUT presents a word.
module tb_icpu_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- DUT A: OPC_W=4, REG_W=4, NSRC=2, CNT_W=16 (INSTR_W=16)
  logic        rst_a, flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [15:0] in_instr_a;
  logic [3:0]  out_opcode_a, out_dest_a, out_kind_a;
  logic [7:0]  out_src_a;
  logic        out_illegal_a;
  logic [15:0] cnt_a;

  // ---- DUT B: OPC_W=5, REG_W=6, NSRC=3, CNT_W=4 (INSTR_W=29)
  logic        rst_b, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [28:0] in_instr_b;
  logic [4:0]  out_opcode_b;
  logic [5:0]  out_dest_b;
  logic [17:0] out_src_b;
  logic [3:0]  out_kind_b;
  logic        out_illegal_b;
  logic [3:0]  cnt_b;

  icpu_decode_stage dut_a (
    .clk(clk), .rst(rst_a), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_instr(in_instr_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_opcode(out_opcode_a), .out_dest(out_dest_a), .out_src(out_src_a),
    .out_kind(out_kind_a), .out_illegal(out_illegal_a), .illegal_cnt(cnt_a)
  );

  icpu_decode_stage #(.OPC_W(5), .REG_W(6), .NSRC(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(in_instr_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_opcode(out_opcode_b), .out_dest(out_dest_b), .out_src(out_src_b),
    .out_kind(out_kind_b), .out_illegal(out_illegal_b), .illegal_cnt(cnt_b)
  );

  typedef struct {
    logic [63:0] opc;
    logic [63:0] dest;
    logic [63:0] src;
    logic [3:0]  kind;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t pend_a, pend_b, ea, eb;
  bit   pend_a_v = 0, pend_b_v = 0, clr_a = 0, clr_b = 0;
  int   n_vec = 0, n_fail = 0;
  int   exp_cnt_a = 0, exp_cnt_b = 0;

  // Reference decode from the field layout and opcode map, for any geometry
  function automatic exp_t model(input logic [63:0] w, input int ow, input int rw, input int ns);
    exp_t        e;
    logic [63:0] rmask;
    rmask  = (64'd1 << rw) - 64'd1;
    e.opc  = (w >> (rw * (1 + ns))) & ((64'd1 << ow) - 64'd1);
    e.dest = (w >> (rw * ns)) & rmask;
    e.src  = 64'd0;
    for (int i = 0; i < ns; i++) begin
      e.src = e.src | (((w >> ((ns - 1 - i) * rw)) & rmask) << (i * rw));
    end
    e.ill = 1'b0;
    case (e.opc)
      64'd0:   e.kind = 4'b0001;
      64'd1:   e.kind = 4'b0010;
      64'd2:   e.kind = 4'b0100;
      64'd5:   e.kind = 4'b1000;
      default: begin e.kind = 4'b0001; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock of stimulus for A; the expected decode is queued once the word is accepted
  task automatic cyc_a(input bit v, input logic [15:0] w, input bit ordy, input bit fl,
                       input bit r, output bit acc);
    @(posedge clk);
    if (clr_a) begin qa.delete(); clr_a = 0; end
    if (pend_a_v) begin qa.push_back(pend_a); pend_a_v = 0; end
    #1;
    in_valid_a = v; in_instr_a = w; out_ready_a = ordy; flush_a = fl; rst_a = r;
    #1;
    acc = v && in_ready_a && !fl && !r;
    if (acc) begin pend_a = model({48'd0, w}, 4, 4, 2); pend_a_v = 1; end
    clr_a = fl || r;
  endtask

  task automatic cyc_b(input bit v, input logic [28:0] w, input bit r, output bit acc);
    @(posedge clk);
    if (clr_b) begin qb.delete(); clr_b = 0; end
    if (pend_b_v) begin qb.push_back(pend_b); pend_b_v = 0; end
    #1;
    in_valid_b = v; in_instr_b = w; out_ready_b = 1'b1; flush_b = 1'b0; rst_b = r;
    #1;
    acc = v && in_ready_b && !r;
    if (acc) begin pend_b = model({35'd0, w}, 5, 6, 3); pend_b_v = 1; end
    clr_b = r;
  endtask

  task automatic chk_reset_a();
    chk("a_rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("a_rst_in_ready", 64'(in_ready_a), 64'd0);
    chk("a_rst_opcode", 64'(out_opcode_a), 64'd0);
    chk("a_rst_dest", 64'(out_dest_a), 64'd0);
    chk("a_rst_src", 64'(out_src_a), 64'd0);
    chk("a_rst_kind", 64'(out_kind_a), 64'd1);
    chk("a_rst_illegal", 64'(out_illegal_a), 64'd0);
    chk("a_rst_cnt", 64'(cnt_a), 64'd0);
  endtask

  function automatic logic [15:0] rand_instr_a();
    int          r;
    logic [3:0]  op;
    logic [3:0]  legal [4];
    legal = '{4'd0, 4'd1, 4'd2, 4'd5};
    r = $urandom_range(0, 5);
    op = (r < 4) ? legal[r] : 4'($urandom);
    return {op, 12'($urandom)};
  endfunction

  task automatic run_a();
    bit          acc;
    logic [15:0] stream [4];
    logic [15:0] bp     [3];
    stream = '{16'h1A23, 16'h2B45, 16'h5C00, 16'h0000};
    bp     = '{16'h1111, 16'h2222, 16'h5333};
    cyc_a(0, 16'h0, 0, 0, 1, acc);
    chk("a_in_ready_in_rst", 64'(in_ready_a), 64'd0);
    cyc_a(0, 16'h0, 0, 0, 1, acc);
    chk_reset_a();
    // Full-rate stream
    foreach (stream[i]) begin
      cyc_a(1, stream[i], 1, 0, 0, acc);
      chk("a_stream_accept", 64'(acc), 64'd1);
    end
    repeat (2) cyc_a(0, 16'h0, 1, 0, 0, acc);
    // Illegal opcodes
    cyc_a(1, 16'h3123, 1, 0, 0, acc);
    cyc_a(1, 16'hF456, 1, 0, 0, acc);
    repeat (2) cyc_a(0, 16'h0, 1, 0, 0, acc);
    chk("a_cnt_after_illegal", 64'(cnt_a), 64'd2);
    // Backpressure: two held, third refused until the drain starts
    cyc_a(1, bp[0], 0, 0, 0, acc);
    cyc_a(1, bp[1], 0, 0, 0, acc);
    cyc_a(1, bp[2], 0, 0, 0, acc);
    chk("a_bp_in_ready_third", 64'(in_ready_a), 64'd0);
    cyc_a(1, bp[2], 0, 0, 0, acc);
    chk("a_bp_third_held", 64'(acc), 64'd0);
    acc = 0;
    for (int k = 0; k < 8 && !acc; k++) cyc_a(1, bp[2], 1, 0, 0, acc);
    chk("a_bp_third_accepted", 64'(acc), 64'd1);
    repeat (3) cyc_a(0, 16'h0, 1, 0, 0, acc);
    // Flush while full (one word illegal, must not be counted)
    cyc_a(1, 16'hF0AA, 0, 0, 0, acc);
    cyc_a(1, 16'h2A02, 0, 0, 0, acc);
    cyc_a(1, 16'h5A03, 0, 1, 0, acc);
    cyc_a(0, 16'h0, 0, 0, 0, acc);
    chk("a_flush_out_valid", 64'(out_valid_a), 64'd0);
    chk("a_flush_in_ready", 64'(in_ready_a), 64'd1);
    chk("a_flush_cnt_kept", 64'(cnt_a), 64'd2);
    // Reset mid-stream under backpressure
    cyc_a(1, 16'h1B01, 0, 0, 0, acc);
    cyc_a(1, 16'h3B02, 0, 0, 0, acc);
    cyc_a(0, 16'h0, 0, 0, 1, acc);
    cyc_a(0, 16'h0, 0, 0, 1, acc);
    chk_reset_a();
    cyc_a(1, 16'h1234, 0, 0, 0, acc);
    chk("a_post_rst_accept", 64'(acc), 64'd1);
    cyc_a(0, 16'h0, 1, 0, 0, acc);
    chk("a_post_rst_latency", 64'(out_valid_a), 64'd1);
    cyc_a(0, 16'h0, 1, 0, 0, acc);
    // Random traffic with random backpressure and occasional flush
    for (int n = 0; n < 2000; n++) begin
      cyc_a($urandom_range(0, 3) != 0, rand_instr_a(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 49) == 0, 0, acc);
    end
    repeat (4) cyc_a(0, 16'h0, 1, 0, 0, acc);
  endtask

  task automatic run_b();
    bit acc;
    cyc_b(0, 29'h0, 1, acc);
    cyc_b(0, 29'h0, 1, acc);
    // NEW with src {7,8,9}: src[0]=9 sits next to dest in the packed word
    cyc_b(1, {5'd1, 6'd12, 6'd9, 6'd8, 6'd7}, 0, acc);
    chk("b_new_accept", 64'(acc), 64'd1);
    cyc_b(0, 29'h0, 0, acc);
    chk("b_new_src", 64'(out_src_b), 64'({6'd7, 6'd8, 6'd9}));
    chk("b_new_kind", 64'(out_kind_b), 64'd2);
    cyc_b(1, {5'h11, 24'($urandom)}, 0, acc);
    cyc_b(0, 29'h0, 0, acc);
    chk("b_op11_illegal", 64'(out_illegal_b), 64'd1);
    // Long run of illegal words to saturate the 4-bit counter
    for (int n = 0; n < 20; n++) cyc_b(1, {5'h1F, 24'($urandom)}, 0, acc);
    repeat (2) cyc_b(0, 29'h0, 0, acc);
    chk("b_cnt_saturated", 64'(cnt_b), 64'hF);
    for (int n = 0; n < 300; n++) begin
      cyc_b($urandom_range(0, 3) != 0, 29'($urandom), 0, acc);
    end
    repeat (3) cyc_b(0, 29'h0, 0, acc);
  endtask

  // Monitor A: occupancy, ordering, field stability and counter
  always @(negedge clk) begin
    if (rst_a) begin
      exp_cnt_a = 0;
    end else begin
      chk("a_out_valid", 64'(out_valid_a), 64'(qa.size() != 0));
      chk("a_in_ready", 64'(in_ready_a), 64'(qa.size() < 2));
      chk("a_illegal_cnt", 64'(cnt_a), 64'(exp_cnt_a));
      if (qa.size() != 0 && out_valid_a) begin
        ea = qa[0];
        chk("a_opcode", 64'(out_opcode_a), ea.opc);
        chk("a_dest", 64'(out_dest_a), ea.dest);
        chk("a_src", 64'(out_src_a), ea.src);
        chk("a_kind", 64'(out_kind_a), 64'(ea.kind));
        chk("a_illegal", 64'(out_illegal_a), 64'(ea.ill));
        if (out_ready_a) begin
          void'(qa.pop_front());
          if (ea.ill && exp_cnt_a != 65535) exp_cnt_a++;
        end
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (rst_b) begin
      exp_cnt_b = 0;
    end else begin
      chk("b_out_valid", 64'(out_valid_b), 64'(qb.size() != 0));
      chk("b_in_ready", 64'(in_ready_b), 64'(qb.size() < 2));
      chk("b_illegal_cnt", 64'(cnt_b), 64'(exp_cnt_b));
      if (qb.size() != 0 && out_valid_b) begin
        eb = qb[0];
        chk("b_opcode", 64'(out_opcode_b), eb.opc);
        chk("b_dest", 64'(out_dest_b), eb.dest);
        chk("b_src", 64'(out_src_b), eb.src);
        chk("b_kind", 64'(out_kind_b), 64'(eb.kind));
        chk("b_illegal", 64'(out_illegal_b), 64'(eb.ill));
        if (out_ready_b) begin
          void'(qb.pop_front());
          if (eb.ill && exp_cnt_b != 15) exp_cnt_b++;
        end
      end
    end
  end

  initial begin
    rst_a = 1; flush_a = 0; in_valid_a = 0; in_instr_a = '0; out_ready_a = 0;
    rst_b = 1; flush_b = 0; in_valid_b = 0; in_instr_b = '0; out_ready_b = 0;
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
